branch_pred_ctrl: RTL and testbench

Branch scheduler/controller around the EX-stage branch_unit. It predicts direction at fetch using a BHT of 2-bit saturating counters. It trains the BHT from branch_unit resolution. On a mispredict it sequences the pipeline recovery: a registered redirect plus IF/ID and ID/EX flush. It also keeps branch and mispredict performance counters.

---
 rtl/rv32_pkg.sv | 36 +++
 rtl/branch_bht.sv | 45 ++++
 rtl/branch_pred_ctrl.sv | 96 +++++++++
 tb/tb_branch_pred_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the branch prediction slice.
//   bht_ctr_t     : 2-bit saturating direction counter encoding
//   BHT_INIT      : counter value loaded on reset (weakly not-taken)
//   redir_state_t : redirect sequencer states
//   ctr_step()    : saturating increment/decrement of a counter
package rv32_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_t;

   localparam bht_ctr_t BHT_INIT = WNT;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } redir_state_t;

   // Move one step toward the resolved direction, saturating at both ends.
   function automatic bht_ctr_t ctr_step(input bht_ctr_t c, input logic taken);
      bht_ctr_t r;
      r = c;
      if (taken) begin
         if (c != ST)
            r = bht_ctr_t'(c + 2'd1);
      end else begin
         if (c != SNT)
            r = bht_ctr_t'(c - 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters.
//   clk, rst   : clock, synchronous active-high reset (all entries -> BHT_INIT)
//   rd_idx     : asynchronous read index
//   rd_ctr     : counter at rd_idx (old value when updated in the same cycle)
//   upd_en     : apply a resolution at the next rising edge
//   upd_idx    : entry to update
//   upd_taken  : resolved direction (1 = increment, 0 = decrement)
module branch_bht
   import rv32_pkg::*;
#(
   parameter  int ENTRIES = 64,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_ctr_t         rd_ctr,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   bht_ctr_t ctr_all [ENTRIES];

   // One register per entry: the whole table must clear in a single reset
   // cycle, so it cannot live in block RAM.
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         bht_ctr_t ctr_reg;

         always_ff @(posedge clk) begin
            if (rst)
               ctr_reg <= BHT_INIT;
            else if (upd_en && (upd_idx == IDX_W'(gi)))
               ctr_reg <= ctr_step(ctr_reg, upd_taken);
         end

         assign ctr_all[gi] = ctr_reg;
      end
   endgenerate

   // No write-to-read bypass: a same-cycle update is seen one cycle later.
   assign rd_ctr = ctr_all[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor and mispredict recovery controller.
//   clk, rst          : clock, synchronous active-high reset
//   if_valid, if_pc   : fetch slot; pred_taken is the combinational prediction
//   ex_*              : branch resolution from the EX stage branch unit
//   redirect_valid    : one-cycle pulse, fetch loads redirect_pc
//   redirect_pc       : corrected fetch PC (held between pulses)
//   flush_if_id/id_ex : squash strobes, coincident with redirect_valid
//   perf_branches     : resolved conditional branches (wraps)
//   perf_mispredicts  : mispredicted branches (wraps)
module branch_pred_ctrl
   import rv32_pkg::*;
#(
   parameter int BHT_ENTRIES = 64,
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_pred_taken,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   redir_state_t    state_reg, state_next;
   logic [XLEN-1:0] redirect_pc_reg;
   logic [31:0]     perf_br_reg, perf_mp_reg;
   bht_ctr_t        if_ctr;
   logic            squash, res, mp;
   logic [XLEN-1:0] tgt;

   branch_bht #(
      .ENTRIES (BHT_ENTRIES)
   ) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (if_pc[IDX_W+1:2]),
      .rd_ctr    (if_ctr),
      .upd_en    (res),
      .upd_idx   (ex_pc[IDX_W+1:2]),
      .upd_taken (ex_taken)
   );

   assign pred_taken = if_valid & if_ctr[1];

   // The instruction in EX while the redirect pulse is out is on the wrong
   // path; it must neither train the table nor count.
   assign squash = (state_reg == REDIRECT);
   assign res    = ex_valid & ex_branch & ~squash;
   assign mp     = res & (ex_taken != ex_pred_taken);
   assign tgt    = ex_taken ? ex_target : (ex_pc + XLEN'(4));

   always_comb begin
      state_next = IDLE;
      case (state_reg)
         IDLE:     state_next = mp ? REDIRECT : IDLE;
         REDIRECT: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         redirect_pc_reg <= '0;
         perf_br_reg     <= '0;
         perf_mp_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (mp)
            redirect_pc_reg <= tgt;
         perf_br_reg <= perf_br_reg + 32'(res);
         perf_mp_reg <= perf_mp_reg + 32'(mp);
      end
   end

   assign redirect_valid   = (state_reg == REDIRECT);
   assign flush_if_id      = (state_reg == REDIRECT);
   assign flush_id_ex      = (state_reg == REDIRECT);
   assign redirect_pc      = redirect_pc_reg;
   assign perf_branches    = perf_br_reg;
   assign perf_mispredicts = perf_mp_reg;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: a behavioural model (integer counters,
// a pending-redirect flag) is checked every cycle, plus literal pins.
module tb_branch_pred_ctrl;

   localparam int NENT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid, ex_branch, ex_pred_taken, ex_taken;
   logic [31:0] ex_pc, ex_target;
   logic        redirect_valid, flush_if_id, flush_id_ex;
   logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_pred_ctrl #(
      .BHT_ENTRIES (NENT),
      .XLEN        (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .if_valid         (if_valid),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_pc            (ex_pc),
      .ex_pred_taken    (ex_pred_taken),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .flush_if_id      (flush_if_id),
      .flush_id_ex      (flush_id_ex),
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
   );

   // ---------------- behavioural model ----------------
   int          m_bht [NENT];
   bit          m_pend;
   bit [31:0]   m_rpc, m_br, m_mp;
   bit          model_ok = 1'b0;

   function automatic int midx(input logic [31:0] pc);
      return int'((pc >> 2) % NENT);
   endfunction

   always @(posedge clk) begin
      automatic bit r, miss;
      automatic int i;
      if (rst) begin
         for (int k = 0; k < NENT; k++) m_bht[k] <= 1;
         m_pend   <= 1'b0;
         m_rpc    <= 32'h0;
         m_br     <= 32'h0;
         m_mp     <= 32'h0;
         model_ok <= 1'b1;
      end else begin
         r    = ex_valid && ex_branch && !m_pend;
         miss = r && (ex_taken != ex_pred_taken);
         if (r) begin
            i = midx(ex_pc);
            m_bht[i] <= ex_taken ? ((m_bht[i] == 3) ? 3 : m_bht[i] + 1)
                                 : ((m_bht[i] == 0) ? 0 : m_bht[i] - 1);
            m_br <= m_br + 32'd1;
         end
         if (miss) begin
            m_mp  <= m_mp + 32'd1;
            m_rpc <= ex_taken ? ex_target : ex_pc + 32'd4;
         end
         m_pend <= miss;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         check("cyc_pred_taken", 32'(pred_taken),
               32'(if_valid && (m_bht[midx(if_pc)] >= 2)));
         check("cyc_redirect_valid", 32'(redirect_valid), 32'(m_pend));
         check("cyc_flush_if_id", 32'(flush_if_id), 32'(m_pend));
         check("cyc_flush_id_ex", 32'(flush_id_ex), 32'(m_pend));
         check("cyc_redirect_pc", redirect_pc, m_rpc);
         check("cyc_perf_branches", perf_branches, m_br);
         check("cyc_perf_mispredicts", perf_mispredicts, m_mp);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                           input logic pt, input logic tk, input logic [31:0] tg);
      ex_valid      = v;
      ex_branch     = br;
      ex_pc         = pc;
      ex_pred_taken = pt;
      ex_taken      = tk;
      ex_target     = tg;
      $display("txn: valid=%0d branch=%0d pc=%h pred=%0d taken=%0d target=%h",
               v, br, pc, pt, tk, tg);
   endtask

   task automatic clear_ex();
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      rst = 1'b1;
      if_valid = 1'b1;
      if_pc = 32'h100;
      drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // 1: reset state
      tick();
      @(negedge clk);
      check("t1_pred_in_reset", 32'(pred_taken), 32'h0);
      rst = 1'b0;
      tick();
      @(negedge clk);
      check("t1_redirect_valid", 32'(redirect_valid), 32'h0);
      check("t1_perf_branches", perf_branches, 32'h0);
      check("t1_perf_mispredicts", perf_mispredicts, 32'h0);

      // 2: three taken resolves at 0x100 predicted not-taken
      for (int n = 0; n < 3; n++) begin
         tick();
         drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200);
         tick();
         clear_ex();
         @(negedge clk);
         check("t2_redirect_valid", 32'(redirect_valid), 32'h1);
         check("t2_redirect_pc", redirect_pc, 32'h200);
         check("t2_pred_after_update", 32'(pred_taken), 32'h1);
      end
      check("t2_perf_mispredicts", perf_mispredicts, 32'd3);
      // Counter is 11: one not-taken (correctly predicted) step leaves 10.
      tick();
      drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h200);
      tick();
      clear_ex();
      @(negedge clk);
      check("t2_saturated_pred", 32'(pred_taken), 32'h1);
      check("t2_no_redirect", 32'(redirect_valid), 32'h0);
      check("t2_perf_branches", perf_branches, 32'd4);

      // 3: predicted taken, resolved not-taken
      tick();
      drive_ex(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h300);
      tick();
      clear_ex();
      @(negedge clk);
      check("t3_redirect_pc", redirect_pc, 32'h44);
      check("t3_flush_if_id", 32'(flush_if_id), 32'h1);
      check("t3_flush_id_ex", 32'(flush_id_ex), 32'h1);
      tick();
      @(negedge clk);
      check("t3_pulse_one_cycle", 32'(redirect_valid), 32'h0);

      // 4: mispredict held for two cycles after a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if_pc = 32'h40;
      drive_ex(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h80);
      tick();
      @(negedge clk);
      check("t4_first_redirect", 32'(redirect_valid), 32'h1);
      tick();
      clear_ex();
      @(negedge clk);
      check("t4_second_suppressed", 32'(redirect_valid), 32'h0);
      check("t4_perf_mispredicts", perf_mispredicts, 32'd1);
      check("t4_perf_branches", perf_branches, 32'd1);
      // Counter at 10 (not 11): one not-taken step must drop the prediction.
      drive_ex(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h80);
      tick();
      clear_ex();
      @(negedge clk);
      check("t4_bht_unchanged_by_squashed", 32'(pred_taken), 32'h0);

      // 5: fall-through wrap, then a non-branch that must be ignored
      tick();
      drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h500);
      tick();
      clear_ex();
      @(negedge clk);
      check("t5_wrap_redirect_pc", redirect_pc, 32'h0);
      tick();
      drive_ex(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h600);
      tick();
      clear_ex();
      @(negedge clk);
      check("t5_nonbranch_no_redirect", 32'(redirect_valid), 32'h0);
      check("t5_nonbranch_perf", perf_branches, 32'd3);

      // 6: reset lands on the redirect cycle
      if_pc = 32'h100;
      tick();
      drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200);
      tick();
      clear_ex();
      @(negedge clk);
      check("t6_pulse_before_reset", 32'(redirect_valid), 32'h1);
      check("t6_pred_before_reset", 32'(pred_taken), 32'h1);
      rst = 1'b1;
      drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h200);
      tick();
      @(negedge clk);
      check("t6_redirect_cancelled", 32'(redirect_valid), 32'h0);
      check("t6_bht_reset", 32'(pred_taken), 32'h0);
      check("t6_perf_branches", perf_branches, 32'h0);
      check("t6_perf_mispredicts", perf_mispredicts, 32'h0);
      tick();
      clear_ex();
      rst = 1'b0;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
